shiftrg_ctrl: RTL

SHIFTRG_CTRL -- requirements
Module: shiftrg_ctrl

---
 rtl/shiftrg_pkg.sv | 10 +
 rtl/shiftrg_core.sv | 43 ++++
 rtl/shiftrg_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/shiftrg_pkg.sv
// Shared constants for the shift-register controller: FSM state encoding and default width.
package shiftrg_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shiftrg_core.sv
// Shift-register datapath: parallel load, single-bit shift with serial insert, raw outgoing bit.
module shiftrg_core
   import shiftrg_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             shift,
   input  logic             serial_in,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] q,
   output logic             serial_out
);

   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q;
      if (load) begin
         q_d = data_in;
      end else if (shift) begin
         if (MSB_FIRST) begin
            q_d = {q[WIDTH-2:0], serial_in};
         end else begin
            q_d = {serial_in, q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else begin
         q <= q_d;
      end
   end

   assign serial_out = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/shiftrg_ctrl.sv
// Load/shift/done controller around shiftrg_core: accepts a word, shifts WIDTH bits out while
// sampling WIDTH bits in, then publishes the received word on capture.
module shiftrg_ctrl
   import shiftrg_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   input  logic             stall,
   input  logic             abort,
   input  logic             serial_in,
   output logic             serial_out,
   output logic             shift_en,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] capture
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] capture_q;
   logic [WIDTH-1:0] core_q;
   logic             core_sout;
   logic             load;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_valid) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // abort wins over stall; stall simply freezes everything with no timeout
            if (abort) begin
               state_d = ST_IDLE;
            end else if (!stall) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         capture_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == ST_DONE) begin
            capture_q <= core_q;
         end
      end
   end

   shiftrg_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .shift      (shift_en),
      .serial_in  (serial_in),
      .data_in    (load_data),
      .q          (core_q),
      .serial_out (core_sout)
   );

   // load_ready is gated by rst_n so it reads 0 for the whole time reset is held
   assign load_ready = rst_n & (state_q == ST_IDLE);
   assign shift_en   = (state_q == ST_SHIFT) & ~stall & ~abort;
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign serial_out = core_sout & busy;
   assign capture    = capture_q;

endmodule
